// File: rtl/aib_mac_rx_pattern_checker.sv
// aib_mac_rx_pattern_checker: per-channel incrementing-word checker with lock FSM, saturating counters and error flags
// Optional MAC_RX_CHK_ERR_CAPTURE_EN adds first-mismatch expected/actual capture outputs.
module aib_mac_rx_pattern_checker #(
    parameter int DWIDTH     = 40,
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  i_chk_en,
    input  logic                  i_clr,
    input  logic                  i_data_vld,
    input  logic [2*DWIDTH-1:0]   i_data,
    output logic                  o_locked,
    output logic [1:0]            o_state,
    output logic [CNT_W-1:0]      o_good_cnt,
    output logic [CNT_W-1:0]      o_err_cnt,
    output logic                  o_err_pulse,
    output logic                  o_err_sticky
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
    ,
    output logic [2*DWIDTH-1:0]   o_first_err_exp,
    output logic [2*DWIDTH-1:0]   o_first_err_act
`endif
);
    localparam int W      = 2 * DWIDTH;
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

    state_t            state, state_n;
    logic [W-1:0]      exp_word, exp_n;
    logic [RUN_W-1:0]  run, run_n;
    logic [MISS_W-1:0] miss, miss_n;
    logic              good_hit, err_hit, match;

    assign match    = (i_data == exp_word);
    assign o_state  = state;
    assign o_locked = (state == LOCKED);

    // next-state, sequence tracking and hit classification for the current word
    always_comb begin
        state_n  = state;
        exp_n    = exp_word;
        run_n    = run;
        miss_n   = miss;
        good_hit = 1'b0;
        err_hit  = 1'b0;
        if (!i_chk_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SEARCH;
                    run_n   = '0;
                end
                SEARCH: if (i_data_vld) begin
                    exp_n = i_data + 1'b1;
                    run_n = (run == '0 || !match) ? RUN_W'(1) : run + 1'b1;
                    if (run_n == LOCK_V) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end
                LOCKED: if (i_data_vld) begin
                    exp_n = i_data + 1'b1;
                    if (match) begin
                        good_hit = 1'b1;
                        miss_n   = '0;
                    end else begin
                        err_hit = 1'b1;
                        miss_n  = miss + 1'b1;
                        if (miss_n == UNLOCK_V) begin
                            state_n = SEARCH;
                            run_n   = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FSM, sequence state and status registers; clear only touches counters and sticky flag
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            state        <= IDLE;
            exp_word     <= '0;
            run          <= '0;
            miss         <= '0;
            o_good_cnt   <= '0;
            o_err_cnt    <= '0;
            o_err_pulse  <= 1'b0;
            o_err_sticky <= 1'b0;
        end else begin
            state       <= state_n;
            exp_word    <= exp_n;
            run         <= run_n;
            miss        <= miss_n;
            o_err_pulse <= err_hit;
            if (i_clr) begin
                o_good_cnt   <= '0;
                o_err_cnt    <= '0;
                o_err_sticky <= 1'b0;
            end else begin
                if (good_hit && !(&o_good_cnt)) o_good_cnt <= o_good_cnt + 1'b1;
                if (err_hit && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
                if (err_hit) o_err_sticky <= 1'b1;
            end
        end
    end

`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
    logic cap_done;

    // capture expected/actual of the first mismatch since reset or clear
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn || i_clr) begin
            cap_done        <= 1'b0;
            o_first_err_exp <= '0;
            o_first_err_act <= '0;
        end else if (err_hit && !cap_done) begin
            cap_done        <= 1'b1;
            o_first_err_exp <= exp_word;
            o_first_err_act <= i_data;
        end
    end
`endif
endmodule

// File: tb/tb_aib_mac_rx_pattern_checker.sv
// tb_aib_mac_rx_pattern_checker: directed self-checking bench for the RX pattern checker
module tb_aib_mac_rx_pattern_checker;
    logic        clk = 1'b0;
    logic        rstn, chk_en, clr, vld;
    logic [79:0] data;
    logic        locked, pulse, sticky;
    logic [1:0]  state;
    logic [31:0] good, err;
    logic        s_locked, s_pulse, s_sticky;
    logic [1:0]  s_state;
    logic [1:0]  s_good, s_err;
    logic [79:0] all_ones;
    int          compared = 0;
    int          mismatched = 0;
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
    logic [79:0] cap_exp, cap_act, s_cap_exp, s_cap_act;
`endif

    always #5 clk = ~clk;

    aib_mac_rx_pattern_checker #(.DWIDTH(40), .CNT_W(32)) dut (
        .rd_clk(clk), .rd_rstn(rstn), .i_chk_en(chk_en), .i_clr(clr),
        .i_data_vld(vld), .i_data(data), .o_locked(locked), .o_state(state),
        .o_good_cnt(good), .o_err_cnt(err), .o_err_pulse(pulse), .o_err_sticky(sticky)
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        , .o_first_err_exp(cap_exp), .o_first_err_act(cap_act)
`endif
    );

    aib_mac_rx_pattern_checker #(.DWIDTH(40), .CNT_W(2)) dut_sat (
        .rd_clk(clk), .rd_rstn(rstn), .i_chk_en(chk_en), .i_clr(clr),
        .i_data_vld(vld), .i_data(data), .o_locked(s_locked), .o_state(s_state),
        .o_good_cnt(s_good), .o_err_cnt(s_err), .o_err_pulse(s_pulse), .o_err_sticky(s_sticky)
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        , .o_first_err_exp(s_cap_exp), .o_first_err_act(s_cap_act)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [79:0] w);
        vld  = 1'b1;
        data = w;
        tick();
        vld  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        logic [79:0] rnd [8];
        rnd = '{80'd1000, 80'd7, 80'd500, 80'd3, 80'd900, 80'd20, 80'd66, 80'd2};
        all_ones = '1;
        rstn = 1'b0; chk_en = 1'b0; clr = 1'b0; vld = 1'b0; data = '0;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_locked", locked, 0);
        check("rst_good", good, 0);
        check("rst_err", err, 0);
        check("rst_pulse", pulse, 0);
        check("rst_sticky", sticky, 0);

        rstn = 1'b1; chk_en = 1'b1;
        tick();
        check("idle_to_search", state, 1);
        for (int i = 0; i < 3; i++) send(80'(i));
        check("search_3_words", state, 1);
        send(80'd3);
        check("lock_4th_state", state, 2);
        check("lock_4th_locked", locked, 1);
        for (int i = 4; i < 100; i++) send(80'(i));
        check("t1_good", good, 96);
        check("t1_err", err, 0);
        check("t1_sticky", sticky, 0);
        check("t1_sat_good", s_good, 3);

        for (int i = 100; i < 105; i++) send(80'(i));
        send(80'hDEAD);
        check("t2_err", err, 1);
        check("t2_pulse", pulse, 1);
        check("t2_sticky", sticky, 1);
        check("t2_good", good, 101);
        check("t2_state", state, 2);
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        check("t2_cap_exp", cap_exp, 105);
        check("t2_cap_act", cap_act, 80'hDEAD);
`endif
        send(80'd106);
        check("t2_resync_err", err, 2);
        check("t2_resync_pulse", pulse, 1);
        send(80'd107);
        check("t2_pulse_drop", pulse, 0);
        check("t2_good_after", good, 102);
        for (int i = 108; i < 111; i++) send(80'(i));
        check("t2_good_run", good, 105);
        check("t2_err_held", err, 2);
        check("t2_no_relock", state, 2);

        for (int i = 0; i < 7; i++) send(rnd[i]);
        check("t3_7_state", state, 2);
        check("t3_7_err", err, 9);
        send(rnd[7]);
        check("t3_8_state", state, 1);
        check("t3_8_locked", locked, 0);
        check("t3_8_err", err, 10);
        check("t3_sat_err", s_err, 3);
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        check("t3_cap_frozen_exp", cap_exp, 105);
        check("t3_cap_frozen_act", cap_act, 80'hDEAD);
`endif
        for (int i = 200; i < 203; i++) send(80'(i));
        check("t3_relock_3", state, 1);
        send(80'd203);
        check("t3_relock_4", state, 2);
        check("t3_good_nosearch", good, 105);

        chk_en = 1'b0; vld = 1'b1; data = 80'd204;
        tick();
        vld = 1'b0;
        check("t5_idle", state, 0);
        check("t5_good_held", good, 105);
        check("t5_err_held", err, 10);
        check("t5_sticky_held", sticky, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_good", good, 0);
        check("clr_err", err, 0);
        check("clr_sticky", sticky, 0);
        check("clr_state", state, 0);
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        check("clr_cap_exp", cap_exp, 0);
        check("clr_cap_act", cap_act, 0);
`endif

        chk_en = 1'b1;
        tick();
        check("t4_search", state, 1);
        send(all_ones - 80'd1);
        send(all_ones);
        send(80'd0);
        check("t4_wrap_search", state, 1);
        send(80'd1);
        check("t4_wrap_lock", state, 2);
        send(80'd2);
        check("t4_good", good, 1);
        check("t4_err", err, 0);

        tick();
        tick();
        tick();
        check("t5_gap_good", good, 1);
        check("t5_gap_err", err, 0);
        check("t5_gap_state", state, 2);
        send(80'd3);
        send(80'd4);
        check("t5_after_gap", good, 3);

        vld = 1'b1; data = 80'h55; clr = 1'b1;
        tick();
        vld = 1'b0; clr = 1'b0;
        check("t6_clrmis_pulse", pulse, 1);
        check("t6_clrmis_err", err, 0);
        check("t6_clrmis_sticky", sticky, 0);
        check("t6_clrmis_good", good, 0);
`ifdef MAC_RX_CHK_ERR_CAPTURE_EN
        check("t6_clrmis_cap", cap_act, 0);
`endif
        send(80'h56);
        check("t6_resync_good", good, 1);
        check("t6_resync_pulse", pulse, 0);
        send(80'h99);
        check("t6_pre_rst_sticky", sticky, 1);

        rstn = 1'b0; vld = 1'b1; data = 80'h1234;
        tick();
        rstn = 1'b1; vld = 1'b0;
        check("t6_rst_state", state, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_good", good, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_pulse", pulse, 0);
        check("t6_rst_sticky", sticky, 0);
        tick();
        check("t6_post_rst_search", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
